// File: rtl/accum_pkg.sv
// Shared types and helpers for the accumulator result path: result width,
// rounding bias and saturation bounds used when a sum is captured.
package accum_pkg;

    localparam int RES_BITWIDTH_DEF = 8;
    localparam int CALC_W           = 64;

    typedef logic signed [RES_BITWIDTH_DEF-1:0] res_t;
    typedef logic signed [CALC_W-1:0]           calc_t;

    // Round-half-up bias added before an arithmetic right shift.
    function automatic calc_t round_bias(input int shift);
        if (shift > 0) begin
            return calc_t'(1) <<< (shift - 1);
        end
        return calc_t'(0);
    endfunction

    // Largest value representable in a signed field of width w.
    function automatic calc_t sat_max(input int w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    // Smallest value representable in a signed field of width w.
    function automatic calc_t sat_min(input int w);
        return -(calc_t'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; pointers carry one extra bit so
// full and empty are told apart. A push into a full FIFO is accepted only when
// a pop happens in the same cycle. Head data reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push;
    logic             pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = rd_en & ~empty;
    assign push    = wr_en & (~full | pop);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for pointers and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // State registers; reset empties the FIFO and clears storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/accum_result_reader.sv
// Captures the accumulator output L cycles after a closing beat, rounds and
// saturates it to the result width, and buffers it for a ready/valid consumer.
// Sticky flags record dropped results and saturation events.
module accum_result_reader
    import accum_pkg::*;
#(
    parameter int OUT_BITWIDTH = 10,
    parameter int LOG2_NO_IN   = 1,
    parameter int RES_BITWIDTH = RES_BITWIDTH_DEF,
    parameter int SHIFT        = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           beat_vld,
    input  logic                           beat_last,
    input  logic signed [OUT_BITWIDTH:0]   acc_data,
    output logic signed [RES_BITWIDTH-1:0] res_data,
    output logic                           res_vld,
    input  logic                           res_rdy,
    output logic                           overflow,
    output logic                           sat_flag
);

    localparam int L     = LOG2_NO_IN + 1;
    localparam int EXT_W = OUT_BITWIDTH + 2;

    logic [L-1:0]                  dly_q, dly_d;
    logic                          overflow_q, overflow_d;
    logic                          sat_q, sat_d;
    logic                          cap_stb;

    logic signed [EXT_W-1:0]       ext_sum;
    logic signed [EXT_W-1:0]       biased;
    logic signed [EXT_W-1:0]       shifted;
    calc_t                         wide;
    logic                          clamp_hi;
    logic                          clamp_lo;
    logic signed [RES_BITWIDTH-1:0] res_val;

    logic [RES_BITWIDTH-1:0]       fifo_rd_data;
    logic                          fifo_empty;
    logic                          fifo_full;

    assign cap_stb = dly_q[L-1];

    // Round half up, arithmetic shift, then clamp to the signed result range.
    always_comb begin
        ext_sum  = {acc_data[OUT_BITWIDTH], acc_data};
        biased   = ext_sum + EXT_W'(round_bias(SHIFT));
        shifted  = biased >>> SHIFT;
        wide     = calc_t'(shifted);
        clamp_hi = (wide > sat_max(RES_BITWIDTH));
        clamp_lo = (wide < sat_min(RES_BITWIDTH));
        if (clamp_hi) begin
            res_val = RES_BITWIDTH'(sat_max(RES_BITWIDTH));
        end else if (clamp_lo) begin
            res_val = RES_BITWIDTH'(sat_min(RES_BITWIDTH));
        end else begin
            res_val = RES_BITWIDTH'(wide);
        end
    end

    // Delay line and sticky flag next-state; a full FIFO only drops when no pop.
    always_comb begin
        dly_d      = L'({dly_q, beat_vld & beat_last});
        overflow_d = overflow_q | (cap_stb & fifo_full & ~(res_vld & res_rdy));
        sat_d      = sat_q | (cap_stb & (clamp_hi | clamp_lo));
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q      <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            dly_q      <= dly_d;
            overflow_q <= overflow_d;
            sat_q      <= sat_d;
        end
    end

    sync_fifo #(
        .WIDTH (RES_BITWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cap_stb),
        .wr_data (res_val),
        .rd_en   (res_rdy),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign res_vld  = ~fifo_empty;
    assign res_data = $signed(fifo_rd_data);
    assign overflow = overflow_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_accum_result_reader.sv
// Directed bench for accum_result_reader: latency, rounding/saturation,
// FIFO full/overflow behaviour, reset mid-flight and the single-stage variant.
module tb_accum_result_reader;
    import accum_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               beat_vld;
    logic               beat_last;
    logic signed [10:0] acc_data;
    logic               res_rdy;

    logic signed [7:0]  res_data;
    logic               res_vld;
    logic               overflow;
    logic               sat_flag;

    logic signed [7:0]  res_data0;
    logic               res_vld0;
    logic               overflow0;
    logic               sat_flag0;

    int n_vec;
    int n_err;

    int   vals_a [5];
    res_t exp_a  [5];
    int   vals_b [5];
    res_t exp_b  [5];

    accum_result_reader #(
        .OUT_BITWIDTH (10),
        .LOG2_NO_IN   (1),
        .RES_BITWIDTH (8),
        .SHIFT        (2),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_vld  (beat_vld),
        .beat_last (beat_last),
        .acc_data  (acc_data),
        .res_data  (res_data),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .overflow  (overflow),
        .sat_flag  (sat_flag)
    );

    accum_result_reader #(
        .OUT_BITWIDTH (10),
        .LOG2_NO_IN   (0),
        .RES_BITWIDTH (8),
        .SHIFT        (2),
        .FIFO_DEPTH   (4)
    ) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_vld  (beat_vld),
        .beat_last (beat_last),
        .acc_data  (acc_data),
        .res_data  (res_data0),
        .res_vld   (res_vld0),
        .res_rdy   (res_rdy),
        .overflow  (overflow0),
        .sat_flag  (sat_flag0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closing beat, one idle cycle, then the sum is presented; result visible after.
    task automatic capture_one(input string tag, input int val, input int exp);
        beat_vld  = 1'b1;
        beat_last = 1'b1;
        acc_data  = '0;
        tick();
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        tick();
        acc_data  = 11'(val);
        tick();
        acc_data  = '0;
        check_val({tag, "_vld"}, 64'(res_vld), 1);
        check_val({tag, "_data"}, 64'(res_data), 64'(exp));
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vals_a = '{40, 80, -40, 120, 200};
        exp_a  = '{8'sd10, 8'sd20, -8'sd10, 8'sd30, 8'sd50};
        vals_b = '{-400, 8, 300, 12, 44};
        exp_b  = '{-8'sd100, 8'sd2, 8'sd75, 8'sd3, 8'sd11};

        rst_n     = 1'b0;
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        acc_data  = '0;
        res_rdy   = 1'b1;
        tick();
        tick();
        check_val("rst_vld",  64'(res_vld),  0);
        check_val("rst_data", 64'(res_data), 0);
        check_val("rst_ovf",  64'(overflow), 0);
        check_val("rst_sat",  64'(sat_flag), 0);
        rst_n = 1'b1;
        tick();

        // Latency: last beat in cycle t, sum in t+2, valid in t+3.
        beat_vld  = 1'b1;
        beat_last = 1'b1;
        tick();
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        check_val("lat_t1_vld", 64'(res_vld), 0);
        tick();
        acc_data = 11'sd100;
        check_val("lat_t2_vld", 64'(res_vld), 0);
        tick();
        acc_data = '0;
        check_val("lat_t3_vld",  64'(res_vld),  1);
        check_val("lat_t3_data", 64'(res_data), 25);
        tick();
        check_val("lat_drained", 64'(res_vld), 0);

        // beat_last without beat_vld does nothing.
        beat_last = 1'b1;
        tick();
        beat_last = 1'b0;
        acc_data  = 11'sd55;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("ignore_vld", 64'(res_vld), 0);
        end
        acc_data = '0;

        // Rounding and saturation.
        capture_one("rnd_p6", 6, 2);
        check_val("rnd_p6_sat", 64'(sat_flag), 0);
        capture_one("rnd_m6", -6, -1);
        check_val("rnd_m6_sat", 64'(sat_flag), 0);
        capture_one("sat_hi", 1023, 127);
        check_val("sat_hi_flag", 64'(sat_flag), 1);
        capture_one("sat_lo", -1024, -128);

        // Back-to-back, consumer stalled: four fill, fifth is dropped.
        res_rdy = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin
                check_val("b2b_full_vld",  64'(res_vld),  1);
                check_val("b2b_full_head", 64'(res_data), 64'(exp_a[0]));
                check_val("b2b_full_ovf",  64'(overflow), 0);
            end
            beat_vld  = (k < 5);
            beat_last = (k < 5);
            acc_data  = (k >= 2) ? 11'(vals_a[k-2]) : 11'sd0;
            tick();
        end
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        acc_data  = '0;
        check_val("b2b_drop_ovf",   64'(overflow), 1);
        check_val("b2b_stable",     64'(res_data), 64'(exp_a[0]));
        check_val("b2b_sat_sticky", 64'(sat_flag), 1);
        res_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("b2b_drain", 64'(res_data), 64'(exp_a[i]));
            tick();
        end
        check_val("b2b_empty", 64'(res_vld), 0);
        check_val("b2b_ovf_sticky", 64'(overflow), 1);

        rst_n = 1'b0;
        tick();
        check_val("rst2_ovf", 64'(overflow), 0);
        check_val("rst2_sat", 64'(sat_flag), 0);
        rst_n = 1'b1;
        tick();

        // Full FIFO with push and pop in the same cycle: no drop.
        for (int k = 0; k < 7; k++) begin
            beat_vld  = (k < 5);
            beat_last = (k < 5);
            acc_data  = (k >= 2) ? 11'(vals_b[k-2]) : 11'sd0;
            res_rdy   = (k == 6);
            tick();
        end
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        acc_data  = '0;
        res_rdy   = 1'b0;
        check_val("pp_ovf", 64'(overflow), 0);
        res_rdy = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check_val("pp_drain", 64'(res_data), 64'(exp_b[i]));
            tick();
        end
        check_val("pp_empty", 64'(res_vld), 0);

        // Reset one cycle after a last beat: the capture is lost.
        beat_vld  = 1'b1;
        beat_last = 1'b1;
        tick();
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_val("mid_rst_vld",  64'(res_vld),  0);
        check_val("mid_rst_data", 64'(res_data), 0);
        tick();
        rst_n    = 1'b1;
        acc_data = 11'sd77;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("mid_rst_novld", 64'(res_vld),  0);
            check_val("mid_rst_nodat", 64'(res_data), 0);
        end
        check_val("mid_rst_ovf", 64'(overflow), 0);
        check_val("mid_rst_sat", 64'(sat_flag), 0);
        acc_data = '0;

        // Single-stage delay line: sum sampled one cycle after the last beat.
        beat_vld  = 1'b1;
        beat_last = 1'b1;
        tick();
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        acc_data  = 11'sd60;
        check_val("l1_t1_vld", 64'(res_vld0), 0);
        tick();
        acc_data = '0;
        check_val("l1_t2_vld",  64'(res_vld0),  1);
        check_val("l1_t2_data", 64'(res_data0), 15);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
